// File: rtl/mul_sequencer_if.sv
// EX-stage multiply handshake: instruction/operands in, stall/done/result back.
// Latency: n/a (wires only).  Backpressure: stall is driven by the sequencer.
interface mul_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [3:0]       ALUCtl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, ALUCtl, a, b, flush,
        input  stall, done, result
    );

    modport slave (
        input  start, ALUCtl, a, b, flush,
        output stall, done, result
    );
endinterface

// File: rtl/mul_sequencer.sv
// Iterative shift-add MUL sequencer for the EX stage, STEP multiplier bits per cycle.
// Latency: max(1, ceil(bitlen(b)/STEP)) busy cycles, done pulse the cycle after.
// Backpressure: combinational stall in accept and BUSY cycles; flush squashes.
module mul_sequencer #(
    parameter int         WIDTH   = 64,
    parameter int         STEP    = 1,
    parameter logic [3:0] ALU_MUL = 4'b1010
) (
    input logic            clk,
    input logic            rst_n,
    mul_sequencer_if.slave bus
);
    localparam int NUM_STEPS = WIDTH / STEP;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic             accept;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] mplier_shift;

    assign accept = bus.start & (bus.ALUCtl == ALU_MUL) & ~bus.flush
                  & ((state_q == IDLE) | (state_q == DONE));

    // Partial product of the multiplicand with the low STEP multiplier bits.
    always_comb begin
        partial = '0;
        for (int i = 0; i < STEP; i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
    end

    assign acc_sum      = acc_q + partial;
    assign mplier_shift = mplier_q >> STEP;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        acc_d    = '0;
                        mcand_d  = bus.a;
                        mplier_d = bus.b;
                        cnt_d    = '0;
                        state_d  = BUSY;
                    end else begin
                        state_d  = IDLE;
                    end
                end
                BUSY: begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << STEP;
                    mplier_d = mplier_shift;
                    cnt_d    = cnt_q + 1'b1;
                    // Finish early once no multiplier bits remain to retire.
                    if ((cnt_q == LAST_CNT) || (mplier_shift == '0)) begin
                        state_d  = DONE;
                        result_d = acc_sum;
                        done_d   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign bus.stall  = ~bus.flush & (accept | (state_q == BUSY));
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: STEP=1 and STEP=4 instances.
// Products are predicted at accept time and matched against done pulses.
module tb_mul_sequencer;
    localparam logic [3:0] ALU_MUL = 4'b1010;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [63:0] q1[$];
    logic [63:0] q4[$];

    mul_sequencer_if #(.WIDTH(64)) bus1();
    mul_sequencer_if #(.WIDTH(64)) bus4();

    mul_sequencer #(.WIDTH(64), .STEP(1), .ALU_MUL(ALU_MUL)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    mul_sequencer #(.WIDTH(64), .STEP(4), .ALU_MUL(ALU_MUL)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic int busy_cycles(input logic [63:0] bv, input int step);
        int bl;
        bl = 0;
        for (int i = 0; i < 64; i++) begin
            if (bv[i]) bl = i + 1;
        end
        return (bl == 0) ? 1 : (bl + step - 1) / step;
    endfunction

    // Scoreboard monitors: every done pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (rst_n && bus1.done) begin
            if (q1.size() == 0) check("unexpected_done_s1", 64'd1, 64'd0);
            else check("result_s1", bus1.result, q1.pop_front());
        end
        if (rst_n && bus4.done) begin
            if (q4.size() == 0) check("unexpected_done_s4", 64'd1, 64'd0);
            else check("result_s4", bus4.result, q4.pop_front());
        end
    end

    // Entered just after the posedge of the cycle following accept; counts to done.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        bit seen;
        bit st_ok;
        lat   = 0;
        seen  = 1'b0;
        st_ok = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus1.done) begin
                seen = 1'b1;
                lat  = c;
                break;
            end
            if (!bus1.stall) st_ok = 1'b0;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_stall_busy"}, 64'(st_ok), 64'd1);
        check({tag, "_stall_done"}, 64'(bus1.stall), 64'd0);
    endtask

    task automatic do_mul(input logic [63:0] av, input logic [63:0] bv, input string tag);
        logic [63:0] prod;
        @(posedge clk); #1;
        bus1.start  = 1'b1;
        bus1.ALUCtl = ALU_MUL;
        bus1.a      = av;
        bus1.b      = bv;
        prod        = av * bv;
        q1.push_back(prod);
        @(negedge clk);
        check({tag, "_stall_accept"}, 64'(bus1.stall), 64'd1);
        @(posedge clk); #1;
        bus1.start  = 1'b0;
        bus1.ALUCtl = ALU_ADD;
        wait_done(tag, busy_cycles(bv, 1) + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          dcnt;
        int          lat4;
        logic [63:0] prod;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus1.start = 1'b0; bus1.ALUCtl = ALU_ADD; bus1.a = '0; bus1.b = '0; bus1.flush = 1'b0;
        bus4.start = 1'b0; bus4.ALUCtl = ALU_ADD; bus4.a = '0; bus4.b = '0; bus4.flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 64'(bus1.stall), 64'd0);
        check("rst_done", 64'(bus1.done), 64'd0);
        check("rst_result", bus1.result, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_mul(64'd3, 64'd5, "mul3x5");
        do_mul(ONES, ONES, "ones_s1");

        // STEP=4 instance: 16 busy cycles for a full-width multiplier.
        @(posedge clk); #1;
        bus4.start = 1'b1; bus4.ALUCtl = ALU_MUL; bus4.a = ONES; bus4.b = ONES;
        prod = ONES * ONES;
        q4.push_back(prod);
        @(posedge clk); #1;
        bus4.start = 1'b0; bus4.ALUCtl = ALU_ADD;
        lat4 = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus4.done) begin
                lat4 = c;
                break;
            end
        end
        check("ones_s4_latency", 64'(lat4), 64'(busy_cycles(ONES, 4) + 1));

        do_mul(64'h1234, 64'd0, "b_zero");
        @(posedge clk); #1;
        bus1.start = 1'b1; bus1.ALUCtl = ALU_ADD; bus1.a = 64'd5; bus1.b = 64'd7;
        dcnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("add_stall", 64'(bus1.stall), 64'd0);
            if (bus1.done) dcnt++;
        end
        check("add_no_done", 64'(dcnt), 64'd0);
        check("add_result_held", bus1.result, 64'd0);
        @(posedge clk); #1;
        bus1.start = 1'b0;

        // Back-to-back: second MUL presented in the DONE cycle of the first.
        @(posedge clk); #1;
        bus1.start = 1'b1; bus1.ALUCtl = ALU_MUL; bus1.a = 64'd7; bus1.b = 64'd6;
        q1.push_back(64'd42);
        @(posedge clk); #1;
        bus1.start = 1'b0; bus1.ALUCtl = ALU_ADD;
        wait_done("b2b_first", busy_cycles(64'd6, 1) + 1);
        bus1.start = 1'b1; bus1.ALUCtl = ALU_MUL; bus1.a = 64'd2; bus1.b = 64'd9;
        q1.push_back(64'd18);
        @(posedge clk); #1;
        bus1.start = 1'b0; bus1.ALUCtl = ALU_ADD;
        wait_done("b2b_second", busy_cycles(64'd9, 1) + 1);

        for (int i = 0; i < 4; i++) begin
            do_mul({$urandom, $urandom}, {$urandom, $urandom} >> $urandom_range(0, 63), "rand");
        end

        do_mul(64'd11, 64'd13, "pre_flush");

        // Flush two cycles into a 64-cycle multiply.
        @(posedge clk); #1;
        bus1.start = 1'b1; bus1.ALUCtl = ALU_MUL; bus1.a = 64'd3; bus1.b = 64'h8000_0000_0000_0001;
        @(posedge clk); #1;
        bus1.start = 1'b0; bus1.ALUCtl = ALU_ADD;
        @(posedge clk); #1;
        bus1.flush = 1'b1;
        @(negedge clk);
        check("flush_stall", 64'(bus1.stall), 64'd0);
        @(posedge clk); #1;
        bus1.flush = 1'b0;
        @(negedge clk);
        check("flush_idle_stall", 64'(bus1.stall), 64'd0);
        dcnt = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (bus1.done) dcnt++;
        end
        check("flush_no_done", 64'(dcnt), 64'd0);
        check("flush_result_kept", bus1.result, 64'd143);

        // Asynchronous reset ten cycles into a busy multiply.
        @(posedge clk); #1;
        bus1.start = 1'b1; bus1.ALUCtl = ALU_MUL; bus1.a = 64'd3; bus1.b = ONES;
        @(posedge clk); #1;
        bus1.start = 1'b0; bus1.ALUCtl = ALU_ADD;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_stall", 64'(bus1.stall), 64'd0);
        check("midrst_done", 64'(bus1.done), 64'd0);
        check("midrst_result", bus1.result, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_mul(64'd3, 64'd5, "post_rst");

        repeat (3) @(posedge clk);
        check("sb_empty_s1", 64'(q1.size()), 64'd0);
        check("sb_empty_s4", 64'(q4.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
